// File: rtl/sram_arbiter.sv
// SRAM access arbiter between the SNES cartridge bus (reads) and the AVR bus FSM (reads/writes).
// Optional AVR anti-starvation logic is built when ARB_FAIRNESS_EN is defined.
module sram_arbiter #(
    parameter int ADDR_W     = 21,
    parameter int DATA_W     = 8,
    parameter int WAIT_CYC   = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              avr_clk,
    input  logic              avr_reset,
    input  logic              snes_mode,
    input  logic              snes_req,
    input  logic [ADDR_W-1:0] snes_addr,
    output logic [DATA_W-1:0] snes_rdata,
    output logic              snes_ack,
    input  logic              avr_req,
    input  logic              avr_we,
    input  logic [ADDR_W-1:0] avr_addr,
    input  logic [DATA_W-1:0] avr_wdata,
    output logic [DATA_W-1:0] avr_rdata,
    output logic              avr_ack,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_din,
    output logic [DATA_W-1:0] sram_dout,
    output logic              sram_dout_en,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [1:0]        grant
);

    localparam int CNT_W = $clog2(WAIT_CYC + 1);

    if (WAIT_CYC < 1 || WAIT_CYC > 15 || STARVE_MAX < 1) begin : g_bad_param
        $error("sram_arbiter: illegal WAIT_CYC or STARVE_MAX");
    end

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        RECOVER
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             snes_elig;
    logic             force_avr;
    logic             pick_snes;
    logic             pick_avr;

`ifdef ARB_FAIRNESS_EN
    localparam int SC_W = $clog2(STARVE_MAX + 1);
    logic [SC_W-1:0] starve_cnt;

    // Counts SNES wins that left a pending AVR request waiting; saturates at STARVE_MAX.
    always_ff @(posedge avr_clk or posedge avr_reset) begin
        if (avr_reset) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (pick_avr)
                starve_cnt <= '0;
            else if (pick_snes && avr_req && starve_cnt < SC_W'(STARVE_MAX))
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_comb begin
        force_avr = avr_req && (starve_cnt == SC_W'(STARVE_MAX));
    end
`else
    always_comb begin
        force_avr = 1'b0;
    end
`endif

    always_comb begin
        snes_elig = snes_mode & snes_req;
        pick_snes = snes_elig & ~force_avr;
        pick_avr  = avr_req & ~pick_snes;
    end

    always_ff @(posedge avr_clk or posedge avr_reset) begin
        if (avr_reset) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            sram_dout_en <= 1'b0;
            sram_addr    <= '0;
            sram_dout    <= '0;
            snes_rdata   <= '0;
            avr_rdata    <= '0;
            snes_ack     <= 1'b0;
            avr_ack      <= 1'b0;
            grant        <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_snes) begin
                        grant     <= 2'b01;
                        sram_addr <= snes_addr;
                        sram_ce_n <= 1'b0;
                        sram_oe_n <= 1'b0;
                        wait_cnt  <= CNT_W'(WAIT_CYC);
                        state     <= RD;
                    end else if (pick_avr) begin
                        grant     <= 2'b10;
                        sram_addr <= avr_addr;
                        sram_ce_n <= 1'b0;
                        if (avr_we) begin
                            sram_dout    <= avr_wdata;
                            sram_dout_en <= 1'b1;
                            state        <= WR_SETUP;
                        end else begin
                            sram_oe_n <= 1'b0;
                            wait_cnt  <= CNT_W'(WAIT_CYC);
                            state     <= RD;
                        end
                    end
                end
                RD: begin
                    if (wait_cnt == CNT_W'(1)) begin
                        if (grant == 2'b01) begin
                            snes_rdata <= sram_din;
                            snes_ack   <= 1'b1;
                        end else begin
                            avr_rdata <= sram_din;
                            avr_ack   <= 1'b1;
                        end
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        state     <= RECOVER;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                WR_SETUP: begin
                    sram_we_n <= 1'b0;
                    wait_cnt  <= CNT_W'(WAIT_CYC);
                    state     <= WR_PULSE;
                end
                WR_PULSE: begin
                    if (wait_cnt == CNT_W'(1)) begin
                        // dout_en stays high through RECOVER for data hold after we_n rises
                        sram_ce_n <= 1'b1;
                        sram_we_n <= 1'b1;
                        avr_ack   <= 1'b1;
                        state     <= RECOVER;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RECOVER: begin
                    snes_ack     <= 1'b0;
                    avr_ack      <= 1'b0;
                    sram_dout_en <= 1'b0;
                    grant        <= 2'b00;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter (WAIT_CYC=2, STARVE_MAX=4).
// Fairness expectations follow ARB_FAIRNESS_EN as seen by this compilation.
module tb_sram_arbiter;

    localparam int ADDR_W = 21;
    localparam int DATA_W = 8;

    logic              avr_clk = 1'b0;
    logic              avr_reset = 1'b1;
    logic              snes_mode = 1'b0;
    logic              snes_req = 1'b0;
    logic [ADDR_W-1:0] snes_addr = '0;
    logic [DATA_W-1:0] snes_rdata;
    logic              snes_ack;
    logic              avr_req = 1'b0;
    logic              avr_we = 1'b0;
    logic [ADDR_W-1:0] avr_addr = '0;
    logic [DATA_W-1:0] avr_wdata = '0;
    logic [DATA_W-1:0] avr_rdata;
    logic              avr_ack;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_din = '0;
    logic [DATA_W-1:0] sram_dout;
    logic              sram_dout_en;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;
    logic [1:0]        grant;

    int n_cmp = 0;
    int n_err = 0;
    int sn;
    int av;
    int gn;

    always #5 avr_clk = ~avr_clk;

    sram_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .WAIT_CYC  (2),
        .STARVE_MAX(4)
    ) dut (
        .avr_clk     (avr_clk),
        .avr_reset   (avr_reset),
        .snes_mode   (snes_mode),
        .snes_req    (snes_req),
        .snes_addr   (snes_addr),
        .snes_rdata  (snes_rdata),
        .snes_ack    (snes_ack),
        .avr_req     (avr_req),
        .avr_we      (avr_we),
        .avr_addr    (avr_addr),
        .avr_wdata   (avr_wdata),
        .avr_rdata   (avr_rdata),
        .avr_ack     (avr_ack),
        .sram_addr   (sram_addr),
        .sram_din    (sram_din),
        .sram_dout   (sram_dout),
        .sram_dout_en(sram_dout_en),
        .sram_ce_n   (sram_ce_n),
        .sram_oe_n   (sram_oe_n),
        .sram_we_n   (sram_we_n),
        .grant       (grant)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge avr_clk);
    endtask

    initial begin
        // reset state
        #12;
        check("rst_ce_n", 32'(sram_ce_n), 1);
        check("rst_oe_n", 32'(sram_oe_n), 1);
        check("rst_we_n", 32'(sram_we_n), 1);
        check("rst_dout_en", 32'(sram_dout_en), 0);
        check("rst_acks", {30'd0, snes_ack, avr_ack}, 0);
        check("rst_grant", 32'(grant), 0);
        check("rst_addr", 32'(sram_addr), 0);
        check("rst_rdata", {16'd0, snes_rdata, avr_rdata}, 0);
        tick;
        avr_reset = 1'b0;
        tick;

        // AVR read
        avr_req = 1'b1; avr_we = 1'b0; avr_addr = 21'h04ccf; sram_din = 8'haa;
        tick;
        check("rd_c1_ce_n", 32'(sram_ce_n), 0);
        check("rd_c1_oe_n", 32'(sram_oe_n), 0);
        check("rd_c1_we_n", 32'(sram_we_n), 1);
        check("rd_c1_grant", 32'(grant), 2);
        check("rd_c1_addr", 32'(sram_addr), 32'h04ccf);
        check("rd_c1_ack", 32'(avr_ack), 0);
        avr_addr = 21'h1ffff;
        tick;
        check("rd_c2_oe_n", 32'(sram_oe_n), 0);
        check("rd_c2_addr_latched", 32'(sram_addr), 32'h04ccf);
        check("rd_c2_ack", 32'(avr_ack), 0);
        tick;
        check("rd_c3_ack", 32'(avr_ack), 1);
        check("rd_c3_rdata", 32'(avr_rdata), 32'haa);
        check("rd_c3_oe_n", 32'(sram_oe_n), 1);
        check("rd_c3_ce_n", 32'(sram_ce_n), 1);
        check("rd_c3_grant", 32'(grant), 2);
        avr_req = 1'b0;
        tick;
        check("rd_idle_ack", 32'(avr_ack), 0);
        check("rd_idle_grant", 32'(grant), 0);

        // AVR write
        avr_req = 1'b1; avr_we = 1'b1; avr_addr = 21'h000010; avr_wdata = 8'hee;
        tick;
        check("wr_c1_ce_n", 32'(sram_ce_n), 0);
        check("wr_c1_we_n", 32'(sram_we_n), 1);
        check("wr_c1_oe_n", 32'(sram_oe_n), 1);
        check("wr_c1_dout_en", 32'(sram_dout_en), 1);
        check("wr_c1_dout", 32'(sram_dout), 32'hee);
        check("wr_c1_addr", 32'(sram_addr), 32'h10);
        avr_wdata = 8'h11;
        tick;
        check("wr_c2_we_n", 32'(sram_we_n), 0);
        tick;
        check("wr_c3_we_n", 32'(sram_we_n), 0);
        check("wr_c3_ack", 32'(avr_ack), 0);
        check("wr_c3_dout", 32'(sram_dout), 32'hee);
        tick;
        check("wr_c4_ack", 32'(avr_ack), 1);
        check("wr_c4_we_n", 32'(sram_we_n), 1);
        check("wr_c4_ce_n", 32'(sram_ce_n), 1);
        check("wr_c4_dout_en", 32'(sram_dout_en), 1);
        check("wr_c4_dout", 32'(sram_dout), 32'hee);
        avr_req = 1'b0; avr_we = 1'b0;
        tick;
        check("wr_idle_dout_en", 32'(sram_dout_en), 0);
        check("wr_idle_ack", 32'(avr_ack), 0);
        check("wr_idle_grant", 32'(grant), 0);

        // Collision: SNES first, AVR after one IDLE cycle
        snes_mode = 1'b1; snes_req = 1'b1; snes_addr = 21'h01234;
        avr_req = 1'b1; avr_addr = 21'h00055; sram_din = 8'h3c;
        tick;
        check("col_c1_grant", 32'(grant), 1);
        check("col_c1_addr", 32'(sram_addr), 32'h01234);
        check("col_c1_oe_n", 32'(sram_oe_n), 0);
        tick;
        tick;
        check("col_c3_snes_ack", 32'(snes_ack), 1);
        check("col_c3_snes_rdata", 32'(snes_rdata), 32'h3c);
        check("col_c3_avr_ack", 32'(avr_ack), 0);
        snes_req = 1'b0; sram_din = 8'h5a;
        tick;
        check("col_c4_grant", 32'(grant), 0);
        check("col_c4_snes_ack", 32'(snes_ack), 0);
        tick;
        check("col_c5_grant", 32'(grant), 2);
        check("col_c5_addr", 32'(sram_addr), 32'h55);
        tick;
        tick;
        check("col_c7_avr_ack", 32'(avr_ack), 1);
        check("col_c7_avr_rdata", 32'(avr_rdata), 32'h5a);
        check("col_c7_snes_rdata", 32'(snes_rdata), 32'h3c);
        avr_req = 1'b0;
        tick;

        // snes_mode=0: SNES request ignored
        snes_mode = 1'b0; snes_req = 1'b1;
        avr_req = 1'b1; avr_addr = 21'h00077; sram_din = 8'h99;
        tick;
        check("mode0_c1_grant", 32'(grant), 2);
        check("mode0_c1_addr", 32'(sram_addr), 32'h77);
        tick;
        tick;
        check("mode0_c3_avr_ack", 32'(avr_ack), 1);
        check("mode0_c3_snes_ack", 32'(snes_ack), 0);
        check("mode0_c3_rdata", 32'(avr_rdata), 32'h99);
        avr_req = 1'b0;
        sn = 0; gn = 0;
        repeat (6) begin
            tick;
            if (snes_ack) sn++;
            if (grant != 2'b00) gn++;
        end
        check("mode0_snes_acks", 32'(sn), 0);
        check("mode0_grants", 32'(gn), 0);

        // Fairness / starvation with both requests held
        snes_mode = 1'b1; snes_req = 1'b1; avr_req = 1'b1; avr_we = 1'b0;
        sn = 0; av = 0;
`ifdef ARB_FAIRNESS_EN
        for (int i = 0; i < 100 && av == 0; i++) begin
            tick;
            if (snes_ack) sn++;
            if (avr_ack) av++;
        end
        check("fair_avr_acked", 32'(av), 1);
        check("fair_snes_before_avr", 32'(sn), 4);
`else
        for (int i = 0; i < 200 && sn < 20; i++) begin
            tick;
            if (snes_ack) sn++;
            if (avr_ack) av++;
        end
        check("strict_snes_acks", 32'(sn), 20);
        check("strict_avr_acks", 32'(av), 0);
`endif
        snes_req = 1'b0; avr_req = 1'b0;
        repeat (6) tick;
        check("post_fair_grant", 32'(grant), 0);

        // Reset mid-RD
        snes_req = 1'b1; snes_addr = 21'h00100;
        tick;
        check("rstrd_oe_n_before", 32'(sram_oe_n), 0);
        #2 avr_reset = 1'b1;
        #1;
        check("rstrd_ce_n", 32'(sram_ce_n), 1);
        check("rstrd_oe_n", 32'(sram_oe_n), 1);
        check("rstrd_we_n", 32'(sram_we_n), 1);
        check("rstrd_dout_en", 32'(sram_dout_en), 0);
        check("rstrd_acks", {30'd0, snes_ack, avr_ack}, 0);
        check("rstrd_grant", 32'(grant), 0);
        check("rstrd_snes_rdata", 32'(snes_rdata), 0);
        snes_req = 1'b0;
        tick;
        avr_reset = 1'b0;
        tick;
        check("rstrd_after_grant", 32'(grant), 0);
        check("rstrd_after_ce_n", 32'(sram_ce_n), 1);

        // Reset mid write pulse
        avr_req = 1'b1; avr_we = 1'b1; avr_addr = 21'h00020; avr_wdata = 8'h05;
        tick;
        tick;
        check("rstwr_we_n_before", 32'(sram_we_n), 0);
        check("rstwr_dout_en_before", 32'(sram_dout_en), 1);
        #2 avr_reset = 1'b1;
        #1;
        check("rstwr_we_n", 32'(sram_we_n), 1);
        check("rstwr_ce_n", 32'(sram_ce_n), 1);
        check("rstwr_dout_en", 32'(sram_dout_en), 0);
        check("rstwr_dout", 32'(sram_dout), 0);
        avr_req = 1'b0; avr_we = 1'b0;
        tick;
        avr_reset = 1'b0;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
